// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables (FIPS numbering),
// the forward shift schedule, and small helpers used by the decrypt scheduler.
package des_pkg;

  typedef logic [4:0] round_t;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } sched_state_t;

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Forward left-shift count for rounds 1..16 (index 0 = round 1)
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Result is {C,D} with FIPS bit 1 of C at [56]
  function automatic logic [56:1] pc1(input logic [64:1] key);
    logic [56:1] res;
    res = '0;
    for (int i = 1; i <= 56; i++) begin
      res[57-i] = key[65-PC1_TBL[i-1]];
    end
    return res;
  endfunction

  function automatic logic [1:0] rsh(input round_t r);
    return SHIFT_SCHED[4'(r - 5'd1)];
  endfunction

  function automatic logic [28:1] rotr(input logic [28:1] x, input logic [1:0] n);
    return (n == 2'd1) ? {x[1], x[28:2]} : {x[2:1], x[28:3]};
  endfunction

  function automatic logic key_parity_ok(input logic [64:1] key);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ok = ok & (^key[8*b+1 +: 8]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/Permuted_Choice2.sv
// PC-2 selection of a 48-bit round subkey from the C/D halves.
module Permuted_Choice2
  import des_pkg::*;
(
  input  logic [28:1] c,
  input  logic [28:1] d,
  output logic [48:1] subkey
);

  logic [56:1] cd;

  assign cd = {c, d};

  for (genvar i = 1; i <= 48; i++) begin : g_bit
    assign subkey[49-i] = cd[57-PC2_TBL[i-1]];
  end

endmodule

// File: rtl/des_decrypt_key_sched.sv
// Streams DES subkeys K16..K1 using right rotations of C/D, one per handshake.
// Optional key parity rejection is enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_decrypt_key_sched
  import des_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [64:1] KEY_IN,
  output logic [48:1] SUBKEY,
  output logic        SUBKEY_VALID,
  input  logic        SUBKEY_READY,
  output logic [5:1]  ROUND,
  output logic        BUSY,
  output logic        DONE,
  output logic        PARITY_ERR
);

  // state    | meaning
  // S_IDLE   | waiting for START; ROUND is 0
  // S_STREAM | presenting K[ROUND]; advances on VALID & READY

  sched_state_t state;
  logic [28:1]  c_half;
  logic [28:1]  d_half;
  round_t       round;
  logic         done_q;
  logic         perr_q;
  logic         key_ok;

`ifdef DES_KEY_PARITY_CHECK_EN
  assign key_ok = key_parity_ok(KEY_IN);
`else
  logic unused_key;
  assign unused_key = ^KEY_IN;
  assign key_ok     = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      c_half <= '0;
      d_half <= '0;
      round  <= '0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      perr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            if (key_ok) begin
              // PC-1 output already equals C16/D16, so K16 needs no rotation
              {c_half, d_half} <= pc1(KEY_IN);
              round            <= 5'd16;
              state            <= S_STREAM;
            end else begin
              perr_q <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (SUBKEY_READY) begin
            if (round > 5'd1) begin
              c_half <= rotr(c_half, rsh(round));
              d_half <= rotr(d_half, rsh(round));
              round  <= round - 5'd1;
            end else begin
              round  <= '0;
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  Permuted_Choice2 u_pc2 (
    .c      (c_half),
    .d      (d_half),
    .subkey (SUBKEY)
  );

  assign SUBKEY_VALID = (state == S_STREAM);
  assign BUSY         = (state == S_STREAM);
  assign ROUND        = round;
  assign DONE         = done_q;
  assign PARITY_ERR   = perr_q;

endmodule

// File: tb/tb_des_decrypt_key_sched.sv
// Self-checking bench for des_decrypt_key_sched against a forward-expansion model.
module tb_des_decrypt_key_sched;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [63:0] KEY_IN;
  logic [47:0] SUBKEY;
  logic        SUBKEY_VALID;
  logic        SUBKEY_READY;
  logic [4:0]  ROUND;
  logic        BUSY;
  logic        DONE;
  logic        PARITY_ERR;

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_k [1:16];

  localparam int M_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int M_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_decrypt_key_sched dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .START        (START),
    .KEY_IN       (KEY_IN),
    .SUBKEY       (SUBKEY),
    .SUBKEY_VALID (SUBKEY_VALID),
    .SUBKEY_READY (SUBKEY_READY),
    .ROUND        (ROUND),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .PARITY_ERR   (PARITY_ERR)
  );

  always #5 CLK = ~CLK;

  // Forward FIPS key expansion with left rotations, stored as K1..K16
  task automatic model_fill(input logic [63:0] key);
    bit kb [1:64];
    bit cb [1:28];
    bit db [1:28];
    bit cd [1:56];
    bit t;
    for (int j = 1; j <= 64; j++) kb[j] = key[64-j];
    for (int i = 1; i <= 28; i++) begin
      cb[i] = kb[M_PC1[i-1]];
      db[i] = kb[M_PC1[27+i]];
    end
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < M_SHIFT[r-1]; s++) begin
        t = cb[1];
        for (int i = 1; i < 28; i++) cb[i] = cb[i+1];
        cb[28] = t;
        t = db[1];
        for (int i = 1; i < 28; i++) db[i] = db[i+1];
        db[28] = t;
      end
      for (int i = 1; i <= 28; i++) begin
        cd[i]    = cb[i];
        cd[28+i] = db[i];
      end
      for (int i = 1; i <= 48; i++) exp_k[r][48-i] = cd[M_PC2[i-1]];
    end
  endtask

  function automatic logic [63:0] odd_parity_key();
    logic [63:0] k;
    k = {$urandom, $urandom};
    for (int b = 0; b < 8; b++) k[8*b] = ~(^k[8*b+1 +: 7]);
    return k;
  endfunction

  // Caller must be at a negedge; returns at the negedge of the DONE cycle
  task automatic run_stream(input logic [63:0] key, input bit rnd_ready, input bit poke_start,
                            input bit check_timing, output logic [47:0] first_sk,
                            output logic [47:0] last_sk);
    int idx;
    int cyc;
    bit rdy;
    model_fill(key);
    KEY_IN = key;
    START  = 1'b1;
    SUBKEY_READY = 1'b0;
    @(negedge CLK);
    START  = 1'b0;
    KEY_IN = {$urandom, $urandom};
    idx = 0;
    cyc = 0;
    first_sk = '0;
    last_sk  = '0;
    while (idx < 16 && cyc < 400) begin
      total++;
      if (SUBKEY_VALID !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0 || PARITY_ERR !== 1'b0) begin
        bad++;
        $display("FAIL stream_flags got valid=%b busy=%b done=%b perr=%b exp 1 1 0 0",
                 SUBKEY_VALID, BUSY, DONE, PARITY_ERR);
      end
      total++;
      if (ROUND !== 5'(16 - idx)) begin
        bad++;
        $display("FAIL stream_round got=%0d exp=%0d", ROUND, 16 - idx);
      end
      total++;
      if (SUBKEY !== exp_k[16-idx]) begin
        bad++;
        $display("FAIL stream_subkey key=%h K%0d got=%h exp=%h", key, 16 - idx, SUBKEY, exp_k[16-idx]);
      end
      if (idx == 0) first_sk = SUBKEY;
      if (idx == 15) last_sk = SUBKEY;
      START = 1'b0;
      if (poke_start && ROUND == 5'd9) begin
        START  = 1'b1;
        KEY_IN = {$urandom, $urandom};
      end
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      SUBKEY_READY = rdy;
      if (rdy) idx++;
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    SUBKEY_READY = 1'b0;
    total++;
    if (idx < 16) begin
      bad++;
      $display("FAIL stream_timeout got handshakes=%0d exp=16", idx);
    end
    total++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || SUBKEY_VALID !== 1'b0 || ROUND !== 5'd0) begin
      bad++;
      $display("FAIL done_cycle got done=%b busy=%b valid=%b round=%0d exp 1 0 0 0",
               DONE, BUSY, SUBKEY_VALID, ROUND);
    end
    if (check_timing) begin
      total++;
      if (cyc != 16) begin
        bad++;
        $display("FAIL done_latency got=%0d exp=16", cyc);
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    total++;
    if (SUBKEY !== 48'h0 || SUBKEY_VALID !== 1'b0 || ROUND !== 5'd0 || BUSY !== 1'b0 ||
        DONE !== 1'b0 || PARITY_ERR !== 1'b0) begin
      bad++;
      $display("FAIL %s got sk=%h valid=%b round=%0d busy=%b done=%b perr=%b exp all zero",
               tag, SUBKEY, SUBKEY_VALID, ROUND, BUSY, DONE, PARITY_ERR);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    START = 1'b0;
    SUBKEY_READY = 1'b0;
    KEY_IN = '0;
    repeat (2) @(negedge CLK);
    check_idle_zero("reset_state");
    RESET = 1'b0;
    @(negedge CLK);
    check_idle_zero("post_reset_idle");
  endtask

  task automatic test_known_vector();
    logic [47:0] f, l;
    run_stream(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b1, f, l);
    total++;
    if (f !== 48'hCB3D8B0E17F5) begin
      bad++;
      $display("FAIL known_first got=%h exp=cb3d8b0e17f5", f);
    end
    total++;
    if (l !== 48'h1B02EFFC7072) begin
      bad++;
      $display("FAIL known_last got=%h exp=1b02effc7072", l);
    end
    @(negedge CLK);
    total++;
    if (DONE !== 1'b0 || SUBKEY_VALID !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width got done=%b valid=%b exp 0 0", DONE, SUBKEY_VALID);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] f, l;
    run_stream(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, f, l);
    @(negedge CLK);
  endtask

  task automatic test_start_ignored();
    logic [47:0] f, l;
    run_stream(odd_parity_key(), 1'b1, 1'b1, 1'b0, f, l);
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic [47:0] f, l;
    run_stream(odd_parity_key(), 1'b0, 1'b0, 1'b1, f, l);
    run_stream(odd_parity_key(), 1'b0, 1'b0, 1'b1, f, l);
    run_stream(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, f, l);
    @(negedge CLK);
  endtask

  task automatic test_random_keys();
    logic [47:0] f, l;
    for (int n = 0; n < 100; n++) begin
      run_stream(odd_parity_key(), n[0], 1'b0, 1'b0, f, l);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    logic [47:0] f, l;
    int cyc;
    KEY_IN = 64'h133457799BBCDFF1;
    START  = 1'b1;
    SUBKEY_READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    cyc = 0;
    while (ROUND !== 5'd5 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    total++;
    if (ROUND !== 5'd5) begin
      bad++;
      $display("FAIL reach_round5 got=%0d exp=5", ROUND);
    end
    RESET = 1'b1;
    #1;
    check_idle_zero("reset_mid_stream");
    SUBKEY_READY = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    SUBKEY_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_idle_zero("after_reset_no_done");
    end
    run_stream(64'h0E329232EA6D0D73, 1'b0, 1'b0, 1'b1, f, l);
    @(negedge CLK);
  endtask

  task automatic test_parity();
`ifdef DES_KEY_PARITY_CHECK_EN
    KEY_IN = 64'h123457799BBCDFF1;
    START  = 1'b1;
    SUBKEY_READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    total++;
    if (PARITY_ERR !== 1'b1 || SUBKEY_VALID !== 1'b0 || BUSY !== 1'b0 || ROUND !== 5'd0) begin
      bad++;
      $display("FAIL parity_reject got perr=%b valid=%b busy=%b round=%0d exp 1 0 0 0",
               PARITY_ERR, SUBKEY_VALID, BUSY, ROUND);
    end
    @(negedge CLK);
    total++;
    if (PARITY_ERR !== 1'b0 || SUBKEY_VALID !== 1'b0) begin
      bad++;
      $display("FAIL parity_pulse got perr=%b valid=%b exp 0 0", PARITY_ERR, SUBKEY_VALID);
    end
    SUBKEY_READY = 1'b0;
`else
    logic [47:0] f, l;
    run_stream(64'h123457799BBCDFF1, 1'b0, 1'b0, 1'b1, f, l);
    @(negedge CLK);
    total++;
    if (PARITY_ERR !== 1'b0) begin
      bad++;
      $display("FAIL parity_tied got=%b exp=0", PARITY_ERR);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_random_keys();
    test_reset_mid();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
